// File: rtl/dualrail_channel_sink_sync_pkg.sv
// Shared constants for the dual-rail channel sink: FSM encodings and default sizing.
package dualrail_channel_sink_sync_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_ACK  = 2'd2;

    localparam int DEF_WIDTH    = 8;
    localparam int DEF_CNT_W    = 16;
    localparam int DEF_SYNC_STG = 2;

endpackage

// File: rtl/dualrail_channel_sink_sync_sync_ff_chain.sv
// Reset-to-0 flop chain bringing one asynchronous rail into the clk domain.
module sync_ff_chain #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain_q;
    logic [STAGES-1:0] chain_d;

    always_comb begin
        chain_d = {chain_q[STAGES-2:0], d};
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain_q <= '0;
        end else begin
            chain_q <= chain_d;
        end
    end

    assign q = chain_q[STAGES-1];

endmodule

// File: rtl/dualrail_channel_sink_sync.sv
// Clocked dual-rail four-phase receiver: synchronises rails, acknowledges tokens,
// packs them LSB first into words on a valid/ready port, counts tokens and flags errors.
module dualrail_channel_sink_sync
    import dualrail_channel_sink_sync_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int CNT_W    = DEF_CNT_W,
    parameter int SYNC_STG = DEF_SYNC_STG
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             d0,
    input  logic             d1,
    output logic             e,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] tok_count,
    output logic             err_both
);

    localparam int               IDX_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    logic s0;
    logic s1;

    sync_ff_chain #(.STAGES(SYNC_STG)) u_sync_d0 (.clk(clk), .rst_n(rst_n), .d(d0), .q(s0));
    sync_ff_chain #(.STAGES(SYNC_STG)) u_sync_d1 (.clk(clk), .rst_n(rst_n), .d(d1), .q(s1));

    logic [1:0]       state_q,     state_d;
    logic             e_q,         e_d;
    logic [IDX_W-1:0] bit_idx_q,   bit_idx_d;
    logic [WIDTH-1:0] shift_q,     shift_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic             out_valid_q, out_valid_d;
    logic [CNT_W-1:0] tok_count_q, tok_count_d;
    logic             err_both_q,  err_both_d;
    logic             blocked;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        e_d         = e_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        tok_count_d = tok_count_q;
        err_both_d  = err_both_q;

        // Only the word-completing token can be held off by an unconsumed word.
        blocked = (bit_idx_q == LAST_IDX) && out_valid_q && !out_ready;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                state_d = ST_REQ;
                e_d     = 1'b1;
            end
            ST_REQ: begin
                if (s0 && s1) begin
                    err_both_d = 1'b1;
                end else if ((s0 ^ s1) && !blocked) begin
                    shift_d[bit_idx_q] = s1;
                    tok_count_d        = tok_count_q + CNT_W'(1);
                    e_d                = 1'b0;
                    state_d            = ST_ACK;
                    if (bit_idx_q == LAST_IDX) begin
                        out_data_d  = shift_d;
                        out_valid_d = 1'b1;
                        bit_idx_d   = '0;
                    end else begin
                        bit_idx_d = bit_idx_q + IDX_W'(1);
                    end
                end
            end
            ST_ACK: begin
                if (s0 && s1) begin
                    err_both_d = 1'b1;
                end else if (!s0 && !s1) begin
                    state_d = ST_REQ;
                    e_d     = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                e_d     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            e_q         <= 1'b0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            tok_count_q <= '0;
            err_both_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            e_q         <= e_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            tok_count_q <= tok_count_d;
            err_both_q  <= err_both_d;
        end
    end

    assign e         = e_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign tok_count = tok_count_q;
    assign err_both  = err_both_q;

endmodule

// File: tb/tb_dualrail_channel_sink_sync.sv
// Directed bench for the dual-rail sink; a 4-bit-counter copy shares all inputs to check wrap.
module tb_dualrail_channel_sink_sync;

    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        d0 = 1'b0;
    logic        d1 = 1'b0;
    logic        out_ready = 1'b0;
    logic        e;
    logic [7:0]  out_data;
    logic        out_valid;
    logic [15:0] tok_count;
    logic        err_both;
    logic        e_w4;
    logic [7:0]  out_data_w4;
    logic        out_valid_w4;
    logic [3:0]  tok_count_w4;
    logic        err_both_w4;

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] mon_q[$];

    always #5 clk = ~clk;

    dualrail_channel_sink_sync #(.WIDTH(8), .CNT_W(16), .SYNC_STG(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .d0(d0), .d1(d1), .e(e),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .tok_count(tok_count), .err_both(err_both)
    );

    dualrail_channel_sink_sync #(.WIDTH(8), .CNT_W(4), .SYNC_STG(2)) u_dut_w4 (
        .clk(clk), .rst_n(rst_n), .d0(d0), .d1(d1), .e(e_w4),
        .out_data(out_data_w4), .out_valid(out_valid_w4), .out_ready(out_ready),
        .tok_count(tok_count_w4), .err_both(err_both_w4)
    );

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) mon_q.push_back(out_data);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_e(input logic lvl, output int n);
        n = 0;
        while (e !== lvl && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (e !== lvl) check("e_timeout", {31'd0, e}, {31'd0, lvl});
    endtask

    task automatic send_bit(input logic b, input bit chk_lat);
        int n;
        wait_e(1'b1, n);
        @(negedge clk);
        d0 = ~b;
        d1 = b;
        wait_e(1'b0, n);
        if (chk_lat) check("ack_fall_lat", n, LAT);
        @(negedge clk);
        d0 = 1'b0;
        d1 = 1'b0;
        wait_e(1'b1, n);
        if (chk_lat) check("ack_rise_lat", n, LAT);
    endtask

    task automatic send_word(input logic [7:0] w, input bit chk_lat);
        for (int i = 0; i < 8; i++) send_bit(w[i], chk_lat);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        d0        = 1'b0;
        d1        = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        logic [7:0] w2;

        // Reset behaviour and IDLE -> REQ on the first clock after release
        #2 rst_n = 1'b0;
        #1 check("rst_e_async", {31'd0, e}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_e", {31'd0, e}, 32'd0);
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_tok", {16'd0, tok_count}, 32'd0);
        check("rst_data", {24'd0, out_data}, 32'd0);
        check("rst_err", {31'd0, err_both}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("rel_e_before_clk", {31'd0, e}, 32'd0);
        @(posedge clk);
        #1 check("rel_e_first_clk", {31'd0, e}, 32'd1);

        // One word 1,0,1,1,0,0,1,0 with latency checks on every e edge
        send_word(8'h4D, 1'b1);
        check("w1_data", {24'd0, out_data}, 32'h4D);
        check("w1_valid", {31'd0, out_valid}, 32'd1);
        check("w1_tok", {16'd0, tok_count}, 32'd8);
        @(negedge clk); out_ready = 1'b1;
        @(negedge clk); out_ready = 1'b0;
        #1 check("w1_consumed", {31'd0, out_valid}, 32'd0);

        // Back-pressure: 16 bits with out_ready low
        apply_reset();
        w2 = 8'hA5;
        send_word(8'h4D, 1'b0);
        for (int i = 0; i < 7; i++) send_bit(w2[i], 1'b0);
        check("bp_tok15", {16'd0, tok_count}, 32'd15);
        wait_e(1'b1, n);
        @(negedge clk);
        d0 = ~w2[7];
        d1 = w2[7];
        repeat (8) @(posedge clk);
        #1;
        check("bp_e_held", {31'd0, e}, 32'd1);
        check("bp_data_stable", {24'd0, out_data}, 32'h4D);
        check("bp_valid_held", {31'd0, out_valid}, 32'd1);
        check("bp_tok_held", {16'd0, tok_count}, 32'd15);
        @(negedge clk); out_ready = 1'b1;
        @(negedge clk); out_ready = 1'b0;
        #1;
        check("bp_w2_data", {24'd0, out_data}, 32'hA5);
        check("bp_w2_valid", {31'd0, out_valid}, 32'd1);
        check("bp_tok16", {16'd0, tok_count}, 32'd16);
        check("bp_ack", {31'd0, e}, 32'd0);
        @(negedge clk); d0 = 1'b0; d1 = 1'b0;
        wait_e(1'b1, n);

        // Both rails high in REQ: sticky error, nothing captured
        apply_reset();
        @(negedge clk); d0 = 1'b1; d1 = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("both_err", {31'd0, err_both}, 32'd1);
        check("both_e", {31'd0, e}, 32'd1);
        check("both_tok", {16'd0, tok_count}, 32'd0);
        @(negedge clk); d0 = 1'b0; d1 = 1'b0;
        repeat (5) @(posedge clk);
        #1 check("both_sticky", {31'd0, err_both}, 32'd1);
        send_bit(1'b1, 1'b0);
        check("both_recover_tok", {16'd0, tok_count}, 32'd1);

        // Reset mid-word discards the partial word
        apply_reset();
        for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0);
        @(negedge clk); d1 = 1'b1;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_e", {31'd0, e}, 32'd0);
        check("mid_rst_tok", {16'd0, tok_count}, 32'd0);
        d0 = 1'b0; d1 = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        send_word(8'h3C, 1'b0);
        check("mid_rst_word", {24'd0, out_data}, 32'h3C);
        check("mid_rst_valid", {31'd0, out_valid}, 32'd1);
        check("mid_rst_tok8", {16'd0, tok_count}, 32'd8);

        // 17 bits, consumer always ready: counter wrap on the 4-bit copy, no lost words
        apply_reset();
        mon_q.delete();
        out_ready = 1'b1;
        send_word(8'h4D, 1'b0);
        send_word(8'hA5, 1'b0);
        send_bit(1'b1, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        check("wrap_tok_w4", {28'd0, tok_count_w4}, 32'd1);
        check("wrap_tok_w16", {16'd0, tok_count}, 32'd17);
        check("wrap_words", mon_q.size(), 32'd2);
        if (mon_q.size() >= 2) begin
            check("wrap_word0", {24'd0, mon_q[0]}, 32'h4D);
            check("wrap_word1", {24'd0, mon_q[1]}, 32'hA5);
        end
        check("wrap_valid_clear", {31'd0, out_valid}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
